// File: rtl/rename_table.sv
// Register alias table: maps each architectural register to the ROB tag that will produce it.
// Lookups read registered state only; issue writes win over same-cycle commit clears.
module rename_table #(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             write_rat,
    input  logic [4:0]       rat_dest,
    input  logic [TAG_W-1:0] rat_tag,
    input  logic [4:0]       rs_addr,
    input  logic [4:0]       rt_addr,
    input  logic             commit1,
    input  logic             commit2,
    input  logic [4:0]       commit_addr,
    input  logic [4:0]       commit_addr2,
    input  logic [TAG_W-1:0] commit_tag,
    input  logic [TAG_W-1:0] commit_tag2,
    output logic             rs_busy,
    output logic             rt_busy,
    output logic [TAG_W-1:0] rs_tag,
    output logic [TAG_W-1:0] rt_tag
);

    logic [31:0]            r_valid;
    logic [31:0][TAG_W-1:0] r_tag;

    logic [31:0] w_validNext;
    logic        w_issue;
    logic        w_commit1Hit;
    logic        w_commit2Hit;

    assign w_issue      = write_rat && (rat_dest != 5'd0);
    // A commit only retires the mapping if no younger producer has since renamed the register
    assign w_commit1Hit = commit1 && r_valid[commit_addr]  && (r_tag[commit_addr]  == commit_tag);
    assign w_commit2Hit = commit2 && r_valid[commit_addr2] && (r_tag[commit_addr2] == commit_tag2);

    always_comb begin
        w_validNext = r_valid;
        if (w_commit1Hit) begin
            w_validNext[commit_addr] = 1'b0;
        end
        if (w_commit2Hit) begin
            w_validNext[commit_addr2] = 1'b0;
        end
        if (w_issue) begin
            w_validNext[rat_dest] = 1'b1;
        end
        w_validNext[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= '0;
            r_tag   <= '0;
        end else if (flush) begin
            r_valid <= '0;
        end else begin
            r_valid <= w_validNext;
            if (w_issue) begin
                r_tag[rat_dest] <= rat_tag;
            end
        end
    end

    assign rs_busy = r_valid[rs_addr];
    assign rt_busy = r_valid[rt_addr];
    assign rs_tag  = r_tag[rs_addr];
    assign rt_tag  = r_tag[rt_addr];

endmodule

// File: tb/tb_rename_table.sv
// Scoreboard bench for rename_table: stimulus queues expected lookups per cycle,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_rename_table;

    localparam int TAG_W = 5;

    logic             clk;
    logic             rst;
    logic             flush;
    logic             write_rat;
    logic [4:0]       rat_dest;
    logic [TAG_W-1:0] rat_tag;
    logic [4:0]       rs_addr;
    logic [4:0]       rt_addr;
    logic             commit1;
    logic             commit2;
    logic [4:0]       commit_addr;
    logic [4:0]       commit_addr2;
    logic [TAG_W-1:0] commit_tag;
    logic [TAG_W-1:0] commit_tag2;
    logic             rs_busy;
    logic             rt_busy;
    logic [TAG_W-1:0] rs_tag;
    logic [TAG_W-1:0] rt_tag;

    typedef struct {
        int               cyc;
        logic             rsB;
        logic [TAG_W-1:0] rsT;
        logic             rtB;
        logic [TAG_W-1:0] rtT;
        string            name;
    } expect_t;

    expect_t expQ[$];
    int      cycleCount = 0;
    int      checkCount = 0;
    int      passCount  = 0;

    rename_table #(.TAG_W(TAG_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .write_rat    (write_rat),
        .rat_dest     (rat_dest),
        .rat_tag      (rat_tag),
        .rs_addr      (rs_addr),
        .rt_addr      (rt_addr),
        .commit1      (commit1),
        .commit2      (commit2),
        .commit_addr  (commit_addr),
        .commit_addr2 (commit_addr2),
        .commit_tag   (commit_tag),
        .commit_tag2  (commit_tag2),
        .rs_busy      (rs_busy),
        .rt_busy      (rt_busy),
        .rs_tag       (rs_tag),
        .rt_tag       (rt_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string name, input string field, input int actual, input int required);
        checkCount++;
        if (actual == required) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s.%s actual=%0d required=%0d", name, field, actual, required);
        end
    endtask

    // Monitor: compare every expectation scheduled for this cycle; anything older was missed
    always @(negedge clk) begin
        while (expQ.size() > 0 && expQ[0].cyc <= cycleCount) begin
            expect_t e;
            e = expQ.pop_front();
            if (e.cyc < cycleCount) begin
                checkOutput(e.name, "missed", 0, 1);
            end else begin
                checkOutput(e.name, "rs_busy", int'(rs_busy), int'(e.rsB));
                checkOutput(e.name, "rs_tag",  int'(rs_tag),  int'(e.rsT));
                checkOutput(e.name, "rt_busy", int'(rt_busy), int'(e.rtB));
                checkOutput(e.name, "rt_tag",  int'(rt_tag),  int'(e.rtT));
            end
        end
    end

    task automatic pushExpect(input logic rsB, input int rsT, input logic rtB, input int rtT, input string name);
        expect_t e;
        e.cyc  = cycleCount;
        e.rsB  = rsB;
        e.rsT  = rsT[TAG_W-1:0];
        e.rtB  = rtB;
        e.rtT  = rtT[TAG_W-1:0];
        e.name = name;
        expQ.push_back(e);
    endtask

    task automatic doWrite(input int dest, input int tag);
        write_rat = 1'b1;
        rat_dest  = dest[4:0];
        rat_tag   = tag[TAG_W-1:0];
    endtask

    task automatic doCommit1(input int addr, input int tag);
        commit1     = 1'b1;
        commit_addr = addr[4:0];
        commit_tag  = tag[TAG_W-1:0];
    endtask

    task automatic doCommit2(input int addr, input int tag);
        commit2      = 1'b1;
        commit_addr2 = addr[4:0];
        commit_tag2  = tag[TAG_W-1:0];
    endtask

    task automatic clearControls();
        write_rat = 1'b0;
        commit1   = 1'b0;
        commit2   = 1'b0;
        flush     = 1'b0;
    endtask

    // Lookups in the current cycle reflect state from before this cycle's edge
    task automatic applyStimulus(input int rsA, input int rtA,
                                 input logic rsB, input int rsT,
                                 input logic rtB, input int rtT, input string name);
        rs_addr = rsA[4:0];
        rt_addr = rtA[4:0];
        pushExpect(rsB, rsT, rtB, rtT, name);
        @(posedge clk);
        #1;
        clearControls();
    endtask

    initial begin
        rst = 1'b0;
        clearControls();
        rat_dest = '0; rat_tag = '0;
        commit_addr = '0; commit_tag = '0;
        commit_addr2 = '0; commit_tag2 = '0;
        rs_addr = '0; rt_addr = '0;
        @(posedge clk);
        #1;
        applyStimulus(5, 31, 0, 0, 0, 0, "inReset");
        rst = 1'b1;
        applyStimulus(5, 31, 0, 0, 0, 0, "afterReset");

        doWrite(8, 3);
        applyStimulus(8, 0, 0, 0, 0, 0, "noBypass");
        applyStimulus(8, 8, 1, 3, 1, 3, "map8to3");

        doWrite(8, 7);
        applyStimulus(8, 0, 1, 3, 0, 0, "remap8");
        doCommit1(8, 3);
        applyStimulus(8, 0, 1, 7, 0, 0, "staleCommit");
        doCommit1(8, 7);
        applyStimulus(8, 0, 1, 7, 0, 0, "keptYounger");
        applyStimulus(8, 0, 0, 7, 0, 0, "matchCommit");

        doWrite(8, 7);
        applyStimulus(8, 0, 0, 7, 0, 0, "rewrite8");
        doWrite(8, 12);
        doCommit1(8, 7);
        applyStimulus(8, 0, 1, 7, 0, 0, "issueVsCommit");
        applyStimulus(8, 0, 1, 12, 0, 0, "issueWins");

        doWrite(4, 1);
        applyStimulus(4, 9, 0, 0, 0, 0, "map4");
        doWrite(9, 2);
        applyStimulus(4, 9, 1, 1, 0, 0, "map9");
        doCommit1(4, 1);
        doCommit2(9, 2);
        applyStimulus(4, 9, 1, 1, 1, 2, "dualCommit");
        doWrite(0, 5);
        applyStimulus(4, 9, 0, 1, 0, 2, "dualCleared");
        applyStimulus(0, 0, 0, 0, 0, 0, "reg0Ignored");

        doWrite(10, 20);
        applyStimulus(10, 0, 0, 0, 0, 0, "map10");
        doCommit1(10, 5);
        doCommit2(10, 20);
        applyStimulus(10, 0, 1, 20, 0, 0, "sameRegCommit");
        doWrite(11, 9);
        applyStimulus(10, 0, 0, 20, 0, 0, "commit2Match");
        doCommit1(11, 1);
        doCommit2(11, 2);
        applyStimulus(11, 0, 1, 9, 0, 0, "bothMismatch");
        applyStimulus(11, 0, 1, 9, 0, 0, "stillMapped11");

        doWrite(1, 4);
        applyStimulus(1, 2, 0, 0, 0, 0, "map1");
        doWrite(2, 6);
        applyStimulus(1, 2, 1, 4, 0, 0, "map2");
        flush = 1'b1;
        doWrite(6, 9);
        doCommit1(1, 4);
        applyStimulus(1, 2, 1, 4, 1, 6, "preFlush");
        applyStimulus(6, 1, 0, 0, 0, 4, "flushed");
        applyStimulus(11, 2, 0, 9, 0, 6, "flushedAll");

        doWrite(3, 13);
        applyStimulus(3, 5, 0, 0, 0, 0, "map3");
        doWrite(5, 14);
        applyStimulus(3, 5, 1, 13, 0, 0, "map5");
        doWrite(7, 15);
        rs_addr = 5'd3;
        rt_addr = 5'd5;
        #2;
        rst = 1'b0;
        pushExpect(0, 0, 0, 0, "asyncReset");
        @(posedge clk);
        #1;
        clearControls();
        applyStimulus(3, 5, 0, 0, 0, 0, "heldReset");
        rst = 1'b1;
        doWrite(7, 15);
        applyStimulus(7, 3, 0, 0, 0, 0, "postRelease");
        applyStimulus(7, 3, 1, 15, 0, 0, "firstEdgeNormal");

        for (int i = 0; i < 5 && expQ.size() > 0; i++) begin
            @(posedge clk);
        end
        if (expQ.size() > 0) begin
            checkOutput("drain", "pending", expQ.size(), 0);
        end
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/rename_table.md
RENAME_TABLE -- requirements
Module: rename_table

Interface
REQ-001 SHALL have parameter TAG_W, default 5, meaning ROB tag width; the ROB holds 2^TAG_W = 32 entries.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port flush  input  1  discard all mappings.
REQ-005 SHALL have port write_rat  input  1  issue accepted by ROB; record new mapping.
REQ-006 SHALL have port rat_dest  input  5  architectural destination of the issuing instruction.
REQ-007 SHALL have port rat_tag  input  TAG_W  ROB tag allocated to the issuing instruction.
REQ-008 SHALL have port rs_addr, rt_addr  input  5 each  source register lookups.
REQ-009 SHALL have port commit1, commit2  input  1 each  ROB retiring oldest / second-oldest entry to the RF.
REQ-010 SHALL have port commit_addr, commit_addr2  input  5 each  destination register of each retiring entry.
REQ-011 SHALL have port commit_tag, commit_tag2  input  TAG_W each  ROB tag of each retiring entry.
REQ-012 SHALL have port rs_busy, rt_busy  output  1 each  source is pending in the ROB.
REQ-013 SHALL have port rs_tag, rt_tag  output  TAG_W each  ROB tag producing the source; valid only when busy.

Function
REQ-014 SHALL hold 32 entries, each a valid bit plus a TAG_W-bit tag, one per architectural register.
REQ-015 SHALL drive lookups combinationally from registered state only: rs_busy = valid[rs_addr], rs_tag = tag[rs_addr]; rt likewise.
REQ-016 SHALL NOT bypass same-cycle writes or clears into lookups; the issuing instruction's own destination never affects its own sources.
REQ-017 SHALL on write_rat=1 with rat_dest!=0 set valid[rat_dest]=1 and tag[rat_dest]=rat_tag at the clock edge.
REQ-018 SHALL ignore writes to register 0; valid[0] stays 0 permanently, so lookups of register 0 return busy=0.
REQ-019 SHALL on commit1=1 clear valid[commit_addr] only when valid=1 and tag[commit_addr]==commit_tag; a mismatch means a younger mapping exists, and the entry is left unchanged.
REQ-020 SHALL apply the same conditional clear for commit2/commit_addr2/commit_tag2, independently of commit1 and in the same cycle.
REQ-021 SHALL, when commit1 and commit2 target the same register, clear it if either tag matches.
REQ-022 SHALL give issue write priority over commit clear when both target the same register in one cycle; the result is valid=1 with tag=rat_tag.
REQ-023 SHALL on flush=1 clear all valid bits at the clock edge; flush has priority over write_rat and commits in that cycle, and tags are left unchanged.
REQ-024 SHALL leave untouched entries unchanged every cycle; there is no other state.

Reset
REQ-025 SHALL on rst=0 immediately clear all valid bits and all tags to 0, independent of clk.
REQ-026 SHALL drive rs_busy=rt_busy=0 and rs_tag=rt_tag=0 while in reset and after release until a write occurs.
REQ-027 SHALL discard any in-flight write or commit on reset asserted mid-operation; the first edge after release behaves as normal operation.

Verification
REQ-028 SHALL cover: after reset, rs_addr=5, rt_addr=31 -> rs_busy=rt_busy=0, tags 0.
REQ-029 SHALL cover: write_rat, dest=8, tag=3; in the same cycle rs_addr=8 -> busy=0 that cycle; next cycle -> rs_busy=1, rs_tag=3.
REQ-030 SHALL cover: map r8->3, then r8->7; commit1 addr=8 tag=3 -> r8 stays busy with tag 7; then commit1 addr=8 tag=7 -> r8 not busy.
REQ-031 SHALL cover: r8->7 busy; same cycle write_rat dest=8 tag=12 and commit1 addr=8 tag=7 -> r8 busy with tag 12.
REQ-032 SHALL cover: dual commit r4 tag 1 and r9 tag 2 (both matching) -> both cleared in one edge; also write_rat dest=0 -> rs_addr=0 never busy.
REQ-033 SHALL cover: several registers mapped, flush together with write_rat dest=6 -> all not busy next cycle; rst pulse mid-sequence -> all outputs 0 immediately.
